// File: rtl/fma16_arb.sv
// Two-requester round-robin arbiter and issue/response sequencer for one shared fma16 datapath.
// Define FMA16_ARB_FFLAGS_EN to build the sticky exception-flag register driven on fflags.
module fma16_arb (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_z,
  input  logic [3:0]  req0_op,
  input  logic [1:0]  req0_rm,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_z,
  input  logic [3:0]  req1_op,
  input  logic [1:0]  req1_rm,
  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  output logic [3:0]  fma_op,
  output logic [1:0]  fma_rm,
  input  logic [15:0] fma_result,
  input  logic [3:0]  fma_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  fflags,
  input  logic        fflags_clr
);

  // state | meaning
  // IDLE  | no operation in flight, no response held
  // EXEC  | issue register drives fma16; result captured on the next edge
  // DONE  | response held until rsp_ready; may accept the next op in the same cycle
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state;
  logic   last_grant;
  logic   issue_id;
  logic   can_accept;
  logic   accept;
  logic   grant;

  always_comb begin
    can_accept = reset_n && ((state == IDLE) || ((state == DONE) && rsp_ready));
    accept     = can_accept && (req_valid != 2'b00);
    // With both requesting, the one not granted last time wins.
    grant      = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    req_ready  = 2'b00;
    if (accept) req_ready = grant ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      issue_id   <= 1'b0;
      fma_x      <= '0;
      fma_y      <= '0;
      fma_z      <= '0;
      fma_op     <= '0;
      fma_rm     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (accept) begin
        fma_x      <= grant ? req1_x  : req0_x;
        fma_y      <= grant ? req1_y  : req0_y;
        fma_z      <= grant ? req1_z  : req0_z;
        fma_op     <= grant ? req1_op : req0_op;
        fma_rm     <= grant ? req1_rm : req0_rm;
        last_grant <= grant;
        issue_id   <= grant;
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          rsp_result <= fma_result;
          rsp_flags  <= fma_flags;
          rsp_id     <= issue_id;
          rsp_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FMA16_ARB_FFLAGS_EN
  // A completing op's flags survive a clear arriving on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fflags <= 4'b0000;
    end else if (state == EXEC) begin
      fflags <= (fflags_clr ? 4'b0000 : fflags) | fma_flags;
    end else if (fflags_clr) begin
      fflags <= 4'b0000;
    end
  end
`else
  // Constant zero; the AND keeps the unused clear input referenced.
  assign fflags = 4'b0000 & {4{fflags_clr}};
`endif

endmodule

// File: tb/tb_fma16_arb.sv
// Self-checking bench for fma16_arb: directed test-plan cases plus randomized traffic
// compared every cycle against a transaction-level model; fma16 is a deterministic stub.
module tb_fma16_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req0_x, req0_y, req0_z, req1_x, req1_y, req1_z;
  logic [3:0]  req0_op, req1_op;
  logic [1:0]  req0_rm, req1_rm;
  logic [15:0] fma_x, fma_y, fma_z, fma_result;
  logic [3:0]  fma_op, fma_flags;
  logic [1:0]  fma_rm;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags, fflags;
  logic        fflags_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fma16_arb dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z), .req0_op(req0_op), .req0_rm(req0_rm),
    .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z), .req1_op(req1_op), .req1_rm(req1_rm),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z), .fma_op(fma_op), .fma_rm(fma_rm),
    .fma_result(fma_result), .fma_flags(fma_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .fflags(fflags), .fflags_clr(fflags_clr)
  );

  // fma16 stand-in: exact values for the test-plan operands, a fixed scramble otherwise.
  function automatic logic [19:0] fma_stub(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z, input logic [3:0] op,
                                           input logic [1:0] rm);
    if (x == 16'h4000 && y == 16'h4200 && z == 16'h3C00 && op == 4'b1100)
      return {4'b0000, 16'h4700};
    if (x == 16'h7BFF && y == 16'h7BFF && op == 4'b1000)
      return {4'b0101, (rm == 2'b00) ? 16'h7BFF : 16'h7C00};
    if (x == 16'h0001 && y == 16'h0001 && op == 4'b1000)
      return {4'b0011, 16'h0000};
    return {x[3:0] ^ z[7:4] ^ {op[1:0], rm}, x ^ {y[7:0], y[15:8]} ^ (z + {op, rm, 10'h000})};
  endfunction

  assign {fma_flags, fma_result} = fma_stub(fma_x, fma_y, fma_z, fma_op, fma_rm);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an op in flight, a held response, last-grant pointer, sticky flags.
  logic        m_ptr, m_busy, m_iid, m_rv, m_rid;
  logic [15:0] m_x, m_y, m_z, m_rres;
  logic [3:0]  m_op, m_rflg, m_ff;
  logic [1:0]  m_rm, m_rdy;
  logic [19:0] m_r;

  function automatic logic [1:0] exp_ready();
    if (!reset_n) return 2'b00;
    if (m_busy || (m_rv && !rsp_ready) || req_valid == 2'b00) return 2'b00;
    if (req_valid == 2'b11) return m_ptr ? 2'b01 : 2'b10;
    return req_valid;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr = 1'b1; m_busy = 1'b0; m_iid = 1'b0; m_rv = 1'b0; m_rid = 1'b0;
      m_x = '0; m_y = '0; m_z = '0; m_op = '0; m_rm = '0;
      m_rres = '0; m_rflg = '0; m_ff = '0;
    end else begin
      m_rdy = exp_ready();
      if (m_busy) begin
        m_r    = fma_stub(m_x, m_y, m_z, m_op, m_rm);
        m_rres = m_r[15:0];
        m_rflg = m_r[19:16];
        m_rid  = m_iid;
        m_rv   = 1'b1;
        m_busy = 1'b0;
`ifdef FMA16_ARB_FFLAGS_EN
        m_ff = (fflags_clr ? 4'h0 : m_ff) | m_r[19:16];
`endif
      end else begin
`ifdef FMA16_ARB_FFLAGS_EN
        if (fflags_clr) m_ff = 4'h0;
`endif
        if (m_rv && rsp_ready) m_rv = 1'b0;
        if (m_rdy != 2'b00) begin
          m_x  = m_rdy[1] ? req1_x  : req0_x;
          m_y  = m_rdy[1] ? req1_y  : req0_y;
          m_z  = m_rdy[1] ? req1_z  : req0_z;
          m_op = m_rdy[1] ? req1_op : req0_op;
          m_rm = m_rdy[1] ? req1_rm : req0_rm;
          m_ptr = m_rdy[1];
          m_iid = m_rdy[1];
          m_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, exp_ready());
    chk("rsp_valid", rsp_valid, m_rv);
    chk("fma_x", fma_x, m_x);
    chk("fma_y", fma_y, m_y);
    chk("fma_z", fma_z, m_z);
    chk("fma_op", fma_op, m_op);
    chk("fma_rm", fma_rm, m_rm);
    if (m_rv || !reset_n) begin
      chk("rsp_id", rsp_id, m_rid);
      chk("rsp_result", rsp_result, m_rres);
      chk("rsp_flags", rsp_flags, m_rflg);
    end
    chk("fflags", fflags, m_ff);
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic samp(); @(negedge clk); #1; endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; fflags_clr = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic set0(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                      input logic [3:0] op, input logic [1:0] rm);
    req0_x = x; req0_y = y; req0_z = z; req0_op = op; req0_rm = rm;
  endtask

  // Issue one op from requester 0 and stop at the first response-valid cycle.
  task automatic issue0(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic [3:0] op, input logic [1:0] rm);
    set0(x, y, z, op, rm);
    req_valid = 2'b01; rsp_ready = 1'b1;
    tick(); req_valid = 2'b00;
    tick(); samp();
  endtask

  logic [1:0] gr [4];
  logic       ids [4];
  int         ngr, nrsp;
  logic [3:0] ff_ovf, ff_unf;

  initial begin
`ifdef FMA16_ARB_FFLAGS_EN
    ff_ovf = 4'b0101; ff_unf = 4'b0011;
`else
    ff_ovf = 4'b0000; ff_unf = 4'b0000;
`endif
    reset_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1; fflags_clr = 1'b0;
    set0(16'h1111, 16'h2222, 16'h3333, 4'b1100, 2'b01);
    req1_x = 16'h4444; req1_y = 16'h5555; req1_z = 16'h6666; req1_op = 4'b0100; req1_rm = 2'b10;
    samp();
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_fma_x", fma_x, 16'h0000);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    do_reset();

    // Single op
    set0(16'h4000, 16'h4200, 16'h3C00, 4'b1100, 2'b01);
    req_valid = 2'b01; rsp_ready = 1'b1;
    samp(); chk("single_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    samp(); chk("single_exec_no_rsp", rsp_valid, 1'b0);
    tick(); samp();
    chk("single_rsp_valid", rsp_valid, 1'b1);
    chk("single_rsp_id", rsp_id, 1'b0);
    chk("single_result", rsp_result, 16'h4700);
    chk("single_flags", rsp_flags, 4'b0000);
    tick();

    // Contention from reset
    do_reset();
    req_valid = 2'b11; rsp_ready = 1'b1;
    ngr = 0; nrsp = 0;
    for (int c = 0; c < 9; c++) begin
      samp();
      if (req_ready != 2'b00 && ngr < 4) begin gr[ngr] = req_ready; ngr++; end
      if (rsp_valid) begin if (nrsp < 4) ids[nrsp] = rsp_id; nrsp++; end
      tick();
    end
    chk("cont_grant0", gr[0], 2'b01);
    chk("cont_grant1", gr[1], 2'b10);
    chk("cont_grant2", gr[2], 2'b01);
    chk("cont_grant3", gr[3], 2'b10);
    chk("cont_id0", ids[0], 1'b0);
    chk("cont_id1", ids[1], 1'b1);
    chk("cont_id2", ids[2], 1'b0);
    chk("cont_id3", ids[3], 1'b1);
    chk("cont_rsp_count", nrsp, 4);

    // Backpressure
    do_reset();
    req1_x = 16'h4000; req1_y = 16'h4200; req1_z = 16'h3C00; req1_op = 4'b1100; req1_rm = 2'b01;
    req_valid = 2'b10; rsp_ready = 1'b0;
    samp(); chk("bp_grant1", req_ready, 2'b10);
    tick(); req_valid = 2'b11; tick();
    for (int c = 0; c < 5; c++) begin
      samp();
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_id", rsp_id, 1'b1);
      chk("bp_hold_result", rsp_result, 16'h4700);
      chk("bp_no_ready", req_ready, 2'b00);
      tick();
    end
    req_valid = 2'b10; rsp_ready = 1'b1;
    samp(); chk("bp_release_grant", req_ready, 2'b10);
    tick(); req_valid = 2'b00; tick(); tick();

    // Overflow and sticky flags
    do_reset();
    issue0(16'h7BFF, 16'h7BFF, 16'h0000, 4'b1000, 2'b01);
    chk("ovf_rne_result", rsp_result, 16'h7C00);
    chk("ovf_rne_flags", rsp_flags, 4'b0101);
    chk("ovf_rne_fflags", fflags, ff_ovf);
    issue0(16'h7BFF, 16'h7BFF, 16'h0000, 4'b1000, 2'b00);
    chk("ovf_rz_result", rsp_result, 16'h7BFF);
    tick();
    fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
    samp(); chk("clr_alone", fflags, 4'b0000);
    issue0(16'h7BFF, 16'h7BFF, 16'h0000, 4'b1000, 2'b01);
    chk("ovf_again_fflags", fflags, ff_ovf);
    set0(16'h0001, 16'h0001, 16'h0000, 4'b1000, 2'b01);
    req_valid = 2'b01;
    tick(); req_valid = 2'b00; fflags_clr = 1'b1;
    tick(); fflags_clr = 1'b0;
    samp();
    chk("clr_coincident", fflags, ff_unf);
    chk("unf_flags", rsp_flags, 4'b0011);

    // Reset during EXEC
    set0(16'h7BFF, 16'h7BFF, 16'h0000, 4'b1000, 2'b01);
    req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    reset_n = 1'b0; #1;
    chk("midreset_rsp_valid", rsp_valid, 1'b0);
    chk("midreset_fflags", fflags, 4'b0000);
    tick(); reset_n = 1'b1;
    req_valid = 2'b11;
    samp(); chk("midreset_first_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b00; tick(); tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid  = 2'($urandom_range(0, 3));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      fflags_clr = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: set0(16'h4000, 16'h4200, 16'h3C00, 4'b1100, 2'b01);
        1: set0(16'h7BFF, 16'h7BFF, 16'($urandom), 4'b1000, 2'($urandom_range(0, 3)));
        default: set0(16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 2'($urandom));
      endcase
      req1_x = 16'($urandom); req1_y = 16'($urandom); req1_z = 16'($urandom);
      req1_op = 4'($urandom); req1_rm = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin req1_x = 16'h0001; req1_y = 16'h0001; req1_op = 4'b1000; end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fma16_arb.md
# fma16_arb

Two-requester round-robin arbiter and sequencer for the half-precision fused multiply-add datapath.
- Accepts operations from two independent requester ports over valid/ready handshakes.
- Registers the granted operation into the combinational fma16 datapath and returns the registered result tagged with the requester ID.
- Sits between the issuing units (integer pipe, test harness) and the single shared fma16 instance; optionally maintains a sticky exception-flag register.

## Interface
- Parameters: none. Widths come from the fma16 defines: 16-bit operands, 2-bit roundmode, 4-bit flags {NV,OF,UF,NX}.
- Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  bit i = requester i presents an operation
- req_ready  out  2  bit i = requester i's operation accepted this cycle
- req0_x, req0_y, req0_z / req1_x, req1_y, req1_z  in  16 each  operands
- req0_op / req1_op  in  4 each  {mul, add, negp, negz} datapath controls
- req0_rm / req1_rm  in  2 each  roundmode, forwarded unmodified
- fma_x, fma_y, fma_z  out  16 each  registered operands driven to fma16
- fma_op  out  4  registered controls to fma16
- fma_rm  out  2  registered roundmode to fma16
- fma_result  in  16  fma16 result, combinational from fma_* outputs
- fma_flags  in  4  fma16 flags, combinational from fma_* outputs
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the response
- rsp_result  out  16  registered result
- rsp_flags  out  4  registered flags
- fflags  out  4  sticky OR of completed-op flags; 0 when macro absent
- fflags_clr  in  1  synchronous clear of fflags

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any req_valid, arbitrate, assert req_ready for the winner, latch its operands/op/rm/ID into the issue register, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - fma16 evaluates the issue register.
  - On the edge, capture fma_result, fma_flags and ID into the response register; go to DONE.
  - No req_ready asserted in EXEC.
- DONE:
  - rsp_valid=1.
  - If rsp_ready=0, hold all response outputs stable and assert no req_ready.
  - If rsp_ready=1 and any req_valid, perform arbitration and accept as in IDLE, then go to EXEC (back-to-back).
  - If rsp_ready=1 and no req_valid, go to IDLE.
- Arbitration:
  - 1-bit last-grant pointer; reset value 1, so requester 0 wins first.
  - Only one valid: that one wins.
  - Both valid: winner = ~pointer.
  - Pointer updates to winner only on acceptance.
- req_ready is combinational from state, rsp_ready and req_valid. At most one bit is set, and never set for a non-valid requester.
- Requester inputs are sampled only on the acceptance cycle. Requester-side stability under backpressure is the requester's obligation.
- fma_* outputs change only on acceptance and hold otherwise.
- Sticky flags (macro present):
  - On the EXEC→DONE edge: fflags <= (fflags_clr ? 0 : fflags) | fma_flags.
  - Otherwise fflags_clr zeros fflags.
  - Completion wins over a simultaneous clear.

## Timing
- Reset values (async, reset_n=0):
  - state=IDLE, pointer=1.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, fflags=0.
  - fma_x/y/z=0, fma_op=0, fma_rm=0.
  - req_ready=0 while reset_n=0.
- Reset mid-operation discards the in-flight issue and response without a handshake.
- Latency: accept at edge N, rsp_valid=1 after edge N+1. Two cycles from the request-valid cycle to the first response-valid cycle.
- Throughput: one operation per 2 cycles with rsp_ready held high.
- A combinational path runs from fma_* through fma16 to the response register within one cycle. No path runs from fma_result to any output.

## Configuration
- FMA16_ARB_FFLAGS_EN defined: the sticky fflags register and fflags_clr behave as above.
- FMA16_ARB_FFLAGS_EN undefined:
  - No fflags register is built.
  - fflags is tied to 4'b0000 and fflags_clr is ignored.
  - rsp_flags still reports per-op flags.

## Test plan
- Single op: req0 x=0x4000, y=0x4200, z=0x3C00, op=mul|add, rm=RNE(01) -> req_ready=2'b01 in the request cycle; after two cycles rsp_valid=1, rsp_id=0, rsp_result=0x4700, rsp_flags=0.
- Contention: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 from reset; rsp_id sequence 0,1,0,1; one response per 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_result/rsp_id stable, req_ready=0. Then rsp_ready=1 with req1 valid -> same-cycle acceptance of req1.
- Overflow flags: 0x7BFF*0x7BFF, add=0.
  - rm=RNE -> rsp_result=0x7C00, rsp_flags=4'b0101, fflags=4'b0101.
  - rm=RZ(00) -> rsp_result=0x7BFF.
  - fflags_clr pulsed alone -> fflags=0.
  - fflags_clr coincident with completion -> fflags=new flags only.
- Reset mid-op: reset_n low during EXEC -> rsp_valid=0, fflags=0 immediately. After release, requester 0 wins a simultaneous request.
- Macro undefined: rerun the overflow case -> fflags stays 0000, rsp_flags=0101.
